// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter that shares one single-clock ram (separate write and
//   read ports, registered read) among N_REQ requesters. At most one access
//   is granted per cycle; read data comes back one cycle after the grant,
//   tagged with a one-hot per-requester valid strobe.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req, we             per-requester request and access type (1 = write)
//   addr, wdata         flattened per-requester address / write data
//   gnt                 one-hot combinational grant
//   rvalid, rdata       one-hot read-data valid, shared read data
//   ram_write_enable    ram write strobe
//   ram_address_write   ram write address
//   ram_data_write      ram write data
//   ram_address_read    ram read address
//   ram_data_read       ram registered read data
module ram_port_arbiter #(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8,
  parameter int N_REQ   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           we,
  input  logic [N_REQ*A_WIDTH-1:0]   addr,
  input  logic [N_REQ*D_WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rvalid,
  output logic [D_WIDTH-1:0]         rdata,
  output logic                       ram_write_enable,
  output logic [A_WIDTH-1:0]         ram_address_write,
  output logic [D_WIDTH-1:0]         ram_data_write,
  output logic [A_WIDTH-1:0]         ram_address_read,
  input  logic [D_WIDTH-1:0]         ram_data_read
);

  localparam int            PW   = $clog2(N_REQ);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  logic [PW-1:0]      prio;
  logic [PW-1:0]      win;
  logic               hit;
  logic               sel_we;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;
  logic               rd_pend_p1;
  logic [PW-1:0]      rd_id_p1;

  // ---- stage p0: arbitration and ram port drive (combinational) ----
  // Scan req starting at prio, wrapping; the first set bit wins.
  always_comb begin
    int idx;
    idx       = 0;
    hit       = 1'b0;
    win       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(prio) + i) % N_REQ;
      if (!hit && req[idx]) begin
        hit       = 1'b1;
        win       = PW'(idx);
        sel_we    = we[idx];
        sel_addr  = addr[idx*A_WIDTH +: A_WIDTH];
        sel_wdata = wdata[idx*D_WIDTH +: D_WIDTH];
      end
    end
    // Reset suppresses every grant so nothing reaches the ram.
    if (rst) hit = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (hit) gnt[win] = 1'b1;
  end

  // Unused ports are parked at address 0 so idle cycles are quiet.
  assign ram_write_enable  = hit & sel_we;
  assign ram_address_write = (hit & sel_we)  ? sel_addr  : '0;
  assign ram_data_write    = (hit & sel_we)  ? sel_wdata : '0;
  assign ram_address_read  = (hit & ~sel_we) ? sel_addr  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= '0;
      rd_pend_p1 <= 1'b0;
    end else begin
      rd_pend_p1 <= hit & ~sel_we;
      if (hit) prio <= (win == LAST) ? '0 : win + PW'(1);
    end
  end

  // Requester tag only matters when rd_pend_p1 is set, so it is reloaded
  // every cycle without reset.
  always_ff @(posedge clk) begin
    rd_id_p1 <= win;
  end

  // ---- stage p1: read data return ----
  // rvalid is masked during reset so a read granted just before reset
  // never produces a strobe.
  always_comb begin
    rvalid = '0;
    if (rd_pend_p1 && !rst) rvalid[rd_id_p1] = 1'b1;
  end

  assign rdata = ram_data_read;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Single-clock round-robin arbiter that shares one `ram` instance (separate write/read ports, registered read) among `N_REQ` requesters. Each cycle it grants at most one read or write access. It drives the RAM's write and read ports from the winning requester and returns read data with a per-requester valid strobe. It sits between client logic (DMA, CPU-side bus, test sequencers) and the `ram` macro. Both RAM clocks are tied to `clk`.

## Interface

Parameters:
- `A_WIDTH`, 4: address width; must match the attached `ram`.
- `D_WIDTH`, 8: data width; must match the attached `ram`.
- `N_REQ`, 2: number of requesters, 2..8.

Ports:
- `clk`  in  1  sole clock; the RAM's `clk_write` and `clk_read` are connected to it.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  per-requester access request; held until granted.
- `we`  in  N_REQ  per-requester access type; 1 = write, 0 = read. Valid while `req` is high.
- `addr`  in  N_REQ*A_WIDTH  flattened addresses; requester i occupies `[i*A_WIDTH +: A_WIDTH]`.
- `wdata`  in  N_REQ*D_WIDTH  flattened write data, same packing.
- `gnt`  out  N_REQ  one-hot grant (combinational); the access completes on the clk edge ending the cycle.
- `rvalid`  out  N_REQ  one-hot, registered; read data for requester i is valid this cycle.
- `rdata`  out  D_WIDTH  shared read data; meaningful only when some `rvalid` bit is high.
- `ram_write_enable`  out  1  to `ram.write_enable`.
- `ram_address_write`  out  A_WIDTH  to `ram.address_write`.
- `ram_data_write`  out  D_WIDTH  to `ram.data_write`.
- `ram_address_read`  out  A_WIDTH  to `ram.address_read`.
- `ram_data_read`  in  D_WIDTH  from `ram.data_read`; registered inside the RAM, so it is valid one cycle after the address is presented.

## Operation

- State:
  - `prio`, a log2(N_REQ)-bit round-robin pointer.
  - `rd_pend`, a 1-bit read-in-flight flag.
  - `rd_id`, the requester index of the read in flight.
- Arbitration, combinational each cycle:
  - Search `req` starting at index `prio` and wrapping modulo N_REQ.
  - The first set bit wins, and `gnt` is one-hot at the winner.
  - If no `req` bit is set, `gnt` = 0.
- Pointer update: on any grant, `prio` <= winner+1 (mod N_REQ). With no grant, `prio` holds.
- Fairness: a continuously requesting client is granted within N_REQ cycles, i.e. at most N_REQ-1 other grants come first.
- Granted write:
  - `ram_write_enable`=1.
  - `ram_address_write` = winner's addr.
  - `ram_data_write` = winner's wdata.
  - The RAM captures at the cycle-ending edge.
  - No `rvalid` is generated.
- Granted read:
  - `ram_address_read` = winner's addr and `ram_write_enable`=0.
  - At the edge, `rd_pend`<=1 and `rd_id`<=winner.
  - Next cycle, `rvalid[rd_id]`=1 and `rdata`=`ram_data_read`.
- Idle cycle:
  - `ram_write_enable`=0 and both RAM addresses are 0.
  - At the edge, `rd_pend`<=0.
- Back-to-back reads are fully pipelined (one per cycle). `rd_pend`/`rd_id` are simply reloaded each cycle.
- Read-after-write to the same address in consecutive cycles returns the new data. The write lands at edge k and the read address is sampled at edge k+1.
- Requests with `req`=0 are ignored regardless of `we`, `addr` and `wdata`.
- Requester contract: `req`, `we`, `addr` and `wdata` stay stable until `gnt` is seen. Deasserting `req` before grant is legal; the request is simply withdrawn.

## Timing

- Reset values, while `rst`=1 and after the edge:
  - `prio`=0, `rd_pend`=0, `rvalid`=0.
  - `rdata` = `ram_data_read` pass-through; don't-care while `rvalid`=0.
  - `gnt` is forced to 0 and `ram_write_enable` is forced to 0 combinationally while `rst`=1.
- Latency:
  - Grant: 0 cycles (same cycle as `req`, if it wins).
  - Write committed: end of the grant cycle.
  - Read data: 1 cycle after grant.
- Reset mid-operation: a read granted in the cycle before `rst` produces no `rvalid`. Assertion of `rst` clears `rd_pend` at that edge, and `rvalid` is 0 during reset.
- Wrap-around: `prio` = N_REQ-1 followed by a grant to N_REQ-1 gives `prio` = 0.
- RAM contents are not cleared by `rst`.

## Test plan

- Reset, then single requester 0 writes 8'hC5 to address 4'hB, then reads 4'hB: `gnt`=2'b01 in both cycles, `ram_write_enable`=1 only in the write cycle, `rvalid`=2'b01 with `rdata`=8'hC5 one cycle after the read grant.
- Both requesters hold `req` for 6 cycles (N_REQ=2, reads to 4'h1 and 4'h2): grants alternate 01,10,01,10,01,10. `rvalid` follows one cycle later with the matching data.
- N_REQ=4 with `req`=4'b1111 continuously: grant order 0,1,2,3,0,1. Drop req[1] and the order skips index 1 with no bubble cycle.
- Requester 1 writes 8'h3A to 4'h7 in cycle k, requester 0 reads 4'h7 in cycle k+1: requester 0 gets `rvalid`=2'b01 with `rdata`=8'h3A in cycle k+2.
- Read granted to requester 1 in cycle k, `rst` asserted in cycle k+1: `rvalid`=0 in k+1 and k+2, `gnt`=0 during reset. The first post-reset grant comes from `prio`=0, i.e. requester 0 wins if both request.
- Idle cycle (`req`=0, `we`=1, garbage addr/wdata): `ram_write_enable`=0, `gnt`=0, and a subsequent read shows the RAM contents unchanged.
